// File: rtl/interface_teclado_pkg.sv
// rtl/interface_teclado_pkg.sv - shared note codes, FSM states and key helpers
// Used by interface_teclado and by the downstream decoder/buzzer.
//   nota_t      : 4-bit note code, 0 = no note, 1..12 = C..B
//   estado_t    : note FSM states
//   lowest_key  : index of the lowest-numbered set key
//   key_to_nota : key index to note code
package interface_teclado_pkg;

  localparam int NUM_TECLAS = 12;
  localparam int NUM_NAV    = 3;
  localparam int NUM_IN     = NUM_TECLAS + NUM_NAV;

  typedef enum logic [3:0] {
    NOTA_NENHUMA = 4'd0,
    NOTA_C       = 4'd1,
    NOTA_CS      = 4'd2,
    NOTA_D       = 4'd3,
    NOTA_DS      = 4'd4,
    NOTA_E       = 4'd5,
    NOTA_F       = 4'd6,
    NOTA_FS      = 4'd7,
    NOTA_G       = 4'd8,
    NOTA_GS      = 4'd9,
    NOTA_A       = 4'd10,
    NOTA_AS      = 4'd11,
    NOTA_B       = 4'd12
  } nota_t;

  typedef enum logic [1:0] {
    LIVRE = 2'd0,
    PRESA = 2'd1,
    PAUSA = 2'd2
  } estado_t;

  // Scans from the top down so the last hit is the lowest index.
  function automatic logic [3:0] lowest_key(input logic [NUM_TECLAS-1:0] k);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_TECLAS - 1; i >= 0; i--) begin
      if (k[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic nota_t key_to_nota(input logic [3:0] k);
    return nota_t'(k + 4'd1);
  endfunction

endpackage

// File: rtl/interface_teclado_if.sv
// rtl/interface_teclado_if.sv - raw key/button inputs and conditioned outputs
// Ports (slave = conditioning block, master = board/testbench side):
//   teclas[11:0], seta_direita, seta_esquerda, enter : raw active-high inputs
//   botoes_encoded[3:0]                              : held note code
//   right_arrow_pressed, left_arrow_pressed,
//   enter_pressed                                    : debounced levels
//   multiplas_teclas                                 : two or more keys down
interface interface_teclado_if;
  import interface_teclado_pkg::*;

  logic [NUM_TECLAS-1:0] teclas;
  logic                  seta_direita;
  logic                  seta_esquerda;
  logic                  enter;
  logic [3:0]            botoes_encoded;
  logic                  right_arrow_pressed;
  logic                  left_arrow_pressed;
  logic                  enter_pressed;
  logic                  multiplas_teclas;

  modport master (
    output teclas, seta_direita, seta_esquerda, enter,
    input  botoes_encoded, right_arrow_pressed, left_arrow_pressed,
           enter_pressed, multiplas_teclas
  );

  modport slave (
    input  teclas, seta_direita, seta_esquerda, enter,
    output botoes_encoded, right_arrow_pressed, left_arrow_pressed,
           enter_pressed, multiplas_teclas
  );

endinterface

// File: rtl/interface_teclado_debouncer.sv
// rtl/interface_teclado_debouncer.sv - 2-FF synchroniser plus counting debouncer
// Ports:
//   clock, reset : system clock, asynchronous active-low reset
//   din_i        : raw asynchronous input
//   level_o      : debounced level
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic din_i,
  output logic level_o
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; on the last mismatching cycle the level flips and the
  // counter clears instead of wrapping.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], din_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/interface_teclado.sv
// rtl/interface_teclado.sv - key/button conditioning and held-note encoder
// Ports:
//   clock, reset : system clock, asynchronous active-low reset
//   bus (slave)  : raw keys/buttons in, note code and debounced levels out
module interface_teclado
  import interface_teclado_pkg::*;
#(
  parameter int CLOCK_FREQ      = 50_000_000,
  parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 100
) (
  input  logic                 clock,
  input  logic                 reset,
  interface_teclado_if.slave   bus
);

  logic [NUM_IN-1:0]     raw;
  logic [NUM_IN-1:0]     stable;
  logic [NUM_TECLAS-1:0] keys;

  assign raw  = {bus.enter, bus.seta_esquerda, bus.seta_direita, bus.teclas};
  assign keys = stable[NUM_TECLAS-1:0];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock   (clock),
      .reset   (reset),
      .din_i   (raw[g]),
      .level_o (stable[g])
    );
  end

  estado_t    state_q, state_d;
  logic [3:0] key_q, key_d;
  nota_t      nota_q, nota_d;
  logic       multi_q, multi_d;

  // PRESA ignores every key except the captured one; PAUSA forces a zero
  // cycle so a downstream edge detector sees back-to-back notes separately.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nota_d  = nota_q;
    // k & (k-1) clears the lowest set bit: non-zero means two or more keys.
    multi_d = (keys & (keys - 12'd1)) != '0;
    case (state_q)
      LIVRE: begin
        nota_d = NOTA_NENHUMA;
        if (|keys) begin
          key_d   = lowest_key(keys);
          nota_d  = key_to_nota(key_d);
          state_d = PRESA;
        end
      end
      PRESA: begin
        if (!keys[key_q]) begin
          nota_d  = NOTA_NENHUMA;
          state_d = PAUSA;
        end
      end
      PAUSA: begin
        nota_d  = NOTA_NENHUMA;
        state_d = LIVRE;
      end
      default: begin
        nota_d  = NOTA_NENHUMA;
        state_d = LIVRE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LIVRE;
      key_q   <= 4'd0;
      nota_q  <= NOTA_NENHUMA;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nota_q  <= nota_d;
      multi_q <= multi_d;
    end
  end

  assign bus.botoes_encoded      = nota_q;
  assign bus.multiplas_teclas    = multi_q;
  assign bus.right_arrow_pressed = stable[NUM_TECLAS];
  assign bus.left_arrow_pressed  = stable[NUM_TECLAS+1];
  assign bus.enter_pressed       = stable[NUM_TECLAS+2];

endmodule

// File: tb/tb_interface_teclado.sv
// tb/tb_interface_teclado.sv - randomized and directed bench for interface_teclado
module tb_interface_teclado;

  localparam int D = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  interface_teclado_if bus();

  interface_teclado #(
    .CLOCK_FREQ      (400),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. An input's accepted level flips once the last D
  // synchronised samples (raw samples from two edges back) all disagree with
  // it. The note logic tracks the held key index and a pending gap.
  logic [14:0] hist [$];
  logic [14:0] m_stable;
  int          m_held;
  int          m_gap;
  int          m_note;
  int          m_multi;

  always @(posedge clock or negedge reset) begin : model
    logic [11:0] k;
    int          lo;
    bit          all_diff;
    if (!reset) begin
      hist = {};
      for (int i = 0; i < D + 2; i++) hist.push_back(15'd0);
      m_stable = '0;
      m_held   = -1;
      m_gap    = 0;
      m_note   = 0;
      m_multi  = 0;
    end else begin
      hist.push_front({bus.enter, bus.seta_esquerda, bus.seta_direita, bus.teclas});
      void'(hist.pop_back());
      k = m_stable[11:0];
      if (m_held >= 0) begin
        if (!k[m_held]) begin
          m_held = -1;
          m_gap  = 1;
          m_note = 0;
        end else begin
          m_note = m_held + 1;
        end
      end else if (m_gap > 0) begin
        m_gap--;
        m_note = 0;
      end else if (k != 0) begin
        lo = -1;
        for (int i = 0; i < 12; i++) if (k[i] && lo < 0) lo = i;
        m_held = lo;
        m_note = lo + 1;
      end else begin
        m_note = 0;
      end
      m_multi = ($countones(k) >= 2) ? 1 : 0;
      for (int i = 0; i < 15; i++) begin
        all_diff = 1'b1;
        for (int j = 2; j < D + 2; j++) if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) m_stable[i] = ~m_stable[i];
      end
    end
  end

  bit mon_en = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      check("note",  int'(bus.botoes_encoded), m_note);
      check("multi", int'(bus.multiplas_teclas), m_multi);
      check("right", int'(bus.right_arrow_pressed), int'(m_stable[12]));
      check("left",  int'(bus.left_arrow_pressed), int'(m_stable[13]));
      check("enter", int'(bus.enter_pressed), int'(m_stable[14]));
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // n counts edges from the one that samples the new input, inclusive.
  task automatic wait_note(input int v, input int budget, output int n);
    n = 0;
    while (int'(bus.botoes_encoded) != v && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic drive_idle();
    bus.teclas        = '0;
    bus.seta_direita  = 1'b0;
    bus.seta_esquerda = 1'b0;
    bus.enter         = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, z, mx, hi, first, any_hi;

    // Scenario 1: reset with everything pressed, then release with key 0 held.
    bus.teclas        = 12'hFFF;
    bus.seta_direita  = 1'b1;
    bus.seta_esquerda = 1'b1;
    bus.enter         = 1'b1;
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (4) tick();
    check("rst_note",  int'(bus.botoes_encoded), 0);
    check("rst_multi", int'(bus.multiplas_teclas), 0);
    check("rst_right", int'(bus.right_arrow_pressed), 0);
    check("rst_left",  int'(bus.left_arrow_pressed), 0);
    check("rst_enter", int'(bus.enter_pressed), 0);
    drive_idle();
    bus.teclas = 12'h001;
    reset = 1'b1;
    wait_note(1, 20, n);
    check("s1_lat", n, D + 3);
    bus.teclas = '0;
    wait_note(0, 20, n);
    repeat (8) tick();

    // Scenario 2: short glitch rejected, long press accepted.
    bus.teclas = 12'h010;
    repeat (3) tick();
    bus.teclas = '0;
    mx = 0;
    repeat (12) begin
      tick();
      if (int'(bus.botoes_encoded) > mx) mx = int'(bus.botoes_encoded);
    end
    check("s2_glitch", mx, 0);
    bus.teclas = 12'h010;
    wait_note(5, 20, n);
    check("s2_lat", n, D + 3);
    repeat (4) tick();
    bus.teclas = '0;
    repeat (12) tick();

    // Scenario 3: held key ignores a second key; gap on release.
    bus.teclas = 12'h004;
    wait_note(3, 20, n);
    check("s3_lat", n, D + 3);
    bus.teclas = 12'h005;
    repeat (10) tick();
    check("s3_hold", int'(bus.botoes_encoded), 3);
    check("s3_multi", int'(bus.multiplas_teclas), 1);
    bus.teclas = 12'h001;
    wait_note(0, 20, n);
    check("s3_rel_lat", n, D + 3);
    z = 0;
    while (int'(bus.botoes_encoded) == 0 && z < 20) begin
      tick();
      z++;
    end
    check("s3_gap", z, 2);
    check("s3_next", int'(bus.botoes_encoded), 1);
    bus.teclas = '0;
    repeat (12) tick();

    // Scenario 4: simultaneous keys, lower index wins.
    bus.teclas = 12'h280;
    wait_note(8, 20, n);
    check("s4_lat", n, D + 3);
    check("s4_note", int'(bus.botoes_encoded), 8);
    bus.teclas = '0;
    repeat (12) tick();

    // Scenario 5: enter pulse passes through delayed; fast arrow toggle blocked.
    bus.enter = 1'b1;
    hi = 0;
    first = -1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 5) bus.enter = 1'b0;
      if (bus.enter_pressed) begin
        hi++;
        if (first < 0) first = c;
      end
    end
    check("s5_enter_len", hi, 5);
    check("s5_enter_first", first, D + 2);
    any_hi = 0;
    for (int c = 0; c < 24; c++) begin
      if (c % 2 == 0) bus.seta_direita = ~bus.seta_direita;
      tick();
      if (bus.right_arrow_pressed) any_hi = 1;
    end
    check("s5_arrow", any_hi, 0);
    drive_idle();
    repeat (12) tick();

    // Scenario 6: asynchronous reset mid-press, then re-debounce.
    bus.teclas = 12'h010;
    wait_note(5, 20, n);
    check("s6_lat", n, D + 3);
    #2 reset = 1'b0;
    #1 check("s6_async", int'(bus.botoes_encoded), 0);
    @(negedge clock);
    tick();
    reset = 1'b1;
    wait_note(5, 20, n);
    check("s6_relat", n, D + 3);
    bus.teclas = '0;
    repeat (12) tick();

    // Random phase: sparse key chords, random navigation, occasional reset.
    for (int it = 0; it < 250; it++) begin
      logic [11:0] kv;
      kv = '0;
      for (int b = 0; b < 12; b++) if ($urandom_range(0, 5) == 0) kv[b] = 1'b1;
      bus.teclas        = kv;
      bus.seta_direita  = 1'($urandom_range(0, 1));
      bus.seta_esquerda = 1'($urandom_range(0, 1));
      bus.enter         = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) tick();
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
      end
    end
    drive_idle();
    repeat (12) tick();
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
